// File: rtl/adder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : adder_pkg
// Brief    : Shared FSM state type and configuration checks for the serial
//            chunk adder.
// Revision : 1.0 - initial release
// ============================================================================
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Legal geometry: at least two bits, and the word splits into whole chunks.
    function automatic bit cfg_ok(input int width, input int chunk);
        return (width >= 2) && (chunk >= 1) && (chunk <= width) && ((width % chunk) == 0);
    endfunction

    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/chunk_adder.sv
`default_nettype none
// ============================================================================
// Module   : chunk_adder
// Brief    : Combinational CHUNK-bit adder reporting carry-out and the carry
//            into its most significant bit.
// Revision : 1.0 - initial release
// ============================================================================
module chunk_adder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co,
    output logic             c_msb_in
);

    logic [CHUNK:0] w_full;

    always_comb begin
        w_full   = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, ci};
        s        = w_full[CHUNK-1:0];
        co       = w_full[CHUNK];
        // The MSB sum bit is a^b^carry_in, so the carry in falls out by XOR.
        c_msb_in = w_full[CHUNK-1] ^ a[CHUNK-1] ^ b[CHUNK-1];
    end

endmodule
`default_nettype wire

// File: rtl/serial_chunk_adder.sv
`default_nettype none
// ============================================================================
// Module   : serial_chunk_adder
// Brief    : Multi-cycle adder processing CHUNK bits per clock with a
//            valid/ready handshake on both sides.
//            Optional macro SERIAL_ADDER_SUB_EN adds a 'sub' input (X - Y).
// Revision : 1.0 - initial release
// ============================================================================
module serial_chunk_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             Cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             Ovf,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int NCH = WIDTH / CHUNK;
    localparam int KW  = idx_width(NCH);
    localparam logic [KW-1:0] K_LAST = KW'(NCH - 1);

    if (!cfg_ok(WIDTH, CHUNK)) begin : g_cfg_err
        $error("serial_chunk_adder: WIDTH must be >= 2 and a multiple of CHUNK");
    end

    state_e           state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic             w_sub;
    logic [CHUNK-1:0] w_a, w_b, w_sum;
    logic             w_co, w_cmsb;

`ifdef SERIAL_ADDER_SUB_EN
    assign w_sub = sub;
`else
    assign w_sub = 1'b0;
`endif

    assign w_a = x_q[int'(k_q)*CHUNK +: CHUNK];
    assign w_b = y_q[int'(k_q)*CHUNK +: CHUNK];

    chunk_adder #(.CHUNK(CHUNK)) u_chunk (
        .a        (w_a),
        .b        (w_b),
        .ci       (carry_q),
        .s        (w_sum),
        .co       (w_co),
        .c_msb_in (w_cmsb)
    );

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        x_d     = x_q;
        y_d     = y_q;
        carry_d = carry_q;
        s_d     = s_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Subtraction is X + ~Y + 1, folded in at capture time.
                    x_d     = X;
                    y_d     = w_sub ? ~Y : Y;
                    carry_d = w_sub ? 1'b1 : Cin;
                    k_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                s_d[int'(k_q)*CHUNK +: CHUNK] = w_sum;
                carry_d = w_co;
                k_d     = k_q + KW'(1);
                if (k_q == K_LAST) begin
                    k_d     = '0;
                    cout_d  = w_co;
                    ovf_d   = w_co ^ w_cmsb;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            x_q     <= '0;
            y_q     <= '0;
            carry_q <= 1'b0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            x_q     <= x_d;
            y_q     <= y_d;
            carry_q <= carry_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign S         = s_q;
    assign Cout      = cout_q;
    assign Ovf       = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_chunk_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_chunk_adder
// Brief    : Directed 8/2 checks and 16/4 random checks of serial_chunk_adder.
//            Define SERIAL_ADDER_SUB_EN to include the subtract cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_chunk_adder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        in_valid8 = 1'b0, out_ready8 = 1'b1, Cin8 = 1'b0, sub8 = 1'b0;
    logic [7:0]  X8 = '0, Y8 = '0;
    logic [7:0]  S8;
    logic        in_ready8, Cout8, Ovf8, out_valid8;

    logic        in_valid16 = 1'b0, out_ready16 = 1'b1, Cin16 = 1'b0, sub16 = 1'b0;
    logic [15:0] X16 = '0, Y16 = '0;
    logic [15:0] S16;
    logic        in_ready16, Cout16, Ovf16, out_valid16;

    serial_chunk_adder #(.WIDTH(8), .CHUNK(2)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .X(X8), .Y(Y8), .Cin(Cin8),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub8),
`endif
        .S(S8), .Cout(Cout8), .Ovf(Ovf8), .out_valid(out_valid8), .out_ready(out_ready8)
    );

    serial_chunk_adder dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
        .X(X16), .Y(Y16), .Cin(Cin16),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub16),
`endif
        .S(S16), .Cout(Cout16), .Ovf(Ovf16), .out_valid(out_valid16), .out_ready(out_ready16)
    );

    int total = 0;
    int bad   = 0;
    logic [9:0]  q8[$];
    logic [17:0] q16[$];
    logic [7:0]  prev8 = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: {Ovf, Cout, S} for an 8-bit add or subtract.
    function automatic logic [9:0] model8(input logic [7:0] x, input logic [7:0] y,
                                          input logic ci, input logic sb);
        logic [7:0] ye;
        logic       c0;
        logic [8:0] f;
        logic       ov;
        ye = sb ? ~y : y;
        c0 = sb ? 1'b1 : ci;
        f  = {1'b0, x} + {1'b0, ye} + {8'd0, c0};
        ov = (x[7] == ye[7]) && (f[7] != x[7]);
        return {ov, f[8], f[7:0]};
    endfunction

    function automatic logic [17:0] model16(input logic [15:0] x, input logic [15:0] y,
                                            input logic ci);
        logic [16:0] f;
        logic        ov;
        f  = {1'b0, x} + {1'b0, y} + {16'd0, ci};
        ov = (x[15] == y[15]) && (f[15] != x[15]);
        return {ov, f[16], f[15:0]};
    endfunction

    task automatic wait_done8(input string tag);
        int lat;
        lat = 0;
        while (!out_valid8 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_latency"}, lat, 4);
        chk({tag, "_result"}, {Ovf8, Cout8, S8}, q8.pop_front());
        chk({tag, "_busy"}, in_ready8, 1'b0);
        prev8 = S8;
    endtask

    // Called #1 after a posedge with dut8 idle; returns idle again.
    task automatic op8(input string tag, input logic [7:0] x, input logic [7:0] y,
                       input logic ci, input logic [9:0] exp);
        chk({tag, "_ready"}, in_ready8, 1'b1);
        q8.push_back(exp);
        X8 = x; Y8 = y; Cin8 = ci; in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        chk({tag, "_s_hold"}, S8, prev8);
        wait_done8(tag);
        @(posedge clk); #1;
        chk({tag, "_release"}, out_valid8, 1'b0);
    endtask

    initial begin
        int seen;
        logic [15:0] rx, ry;
        logic        rc;
        int lat;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_S", S8, 8'h00);
        chk("rst_flags", {Cout8, Ovf8, out_valid8}, 3'b000);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_ready", in_ready8, 1'b1);

        op8("ff_01", 8'hFF, 8'h01, 1'b0, 10'h100);
        op8("7f_01", 8'h7F, 8'h01, 1'b0, 10'h280);
        op8("80_80", 8'h80, 8'h80, 1'b0, 10'h300);
        op8("a5_3c_c", 8'hA5, 8'h3C, 1'b1, model8(8'hA5, 8'h3C, 1'b1, 1'b0));

        // Consumer stalls in DONE while new operands are offered.
        q8.push_back(model8(8'h3C, 8'h21, 1'b1, 1'b0));
        X8 = 8'h3C; Y8 = 8'h21; Cin8 = 1'b1; in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        wait_done8("stall");
        out_ready8 = 1'b0;
        X8 = 8'hAA; Y8 = 8'h55; in_valid8 = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            chk("stall_hold", {out_valid8, in_ready8, Ovf8, Cout8, S8}, {2'b10, 2'b00, 8'h5E});
        end
        out_ready8 = 1'b1;
        @(posedge clk); #1;
        chk("stall_handshake", {out_valid8, in_ready8}, 2'b01);
        q8.push_back(10'h100);
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        chk("stall_accept", in_ready8, 1'b0);
        wait_done8("after_stall");
        @(posedge clk); #1;

        // Reset in the middle of an operation.
        X8 = 8'h0F; Y8 = 8'h00; Cin8 = 1'b0; in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_outputs", {out_valid8, Cout8, Ovf8, S8}, 11'd0);
        #3 rst_n = 1'b1;
        seen = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (out_valid8) seen++;
        end
        chk("abort_no_valid", seen, 0);
        prev8 = 8'h00;
        op8("12_34", 8'h12, 8'h34, 1'b0, 10'h046);

`ifdef SERIAL_ADDER_SUB_EN
        sub8 = 1'b1;
        op8("sub_05_07", 8'h05, 8'h07, 1'b1, 10'h0FE);
        op8("sub_80_01", 8'h80, 8'h01, 1'b0, 10'h37F);
        sub8 = 1'b0;
`endif

        // Random traffic on the default geometry.
        for (int n = 0; n < 10000; n++) begin
            rx = 16'($urandom);
            ry = 16'($urandom);
            rc = 1'($urandom);
            q16.push_back(model16(rx, ry, rc));
            X16 = rx; Y16 = ry; Cin16 = rc; in_valid16 = 1'b1;
            @(posedge clk); #1;
            in_valid16 = 1'b0;
            lat = 0;
            while (!out_valid16 && lat < 20) begin
                @(posedge clk); #1;
                lat++;
            end
            chk("rand_latency", lat, 4);
            chk("rand_result", {Ovf16, Cout16, S16}, q16.pop_front());
            @(posedge clk); #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_chunk_adder.md
SERIAL_CHUNK_ADDER -- requirements
Module: serial_chunk_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/sum width in bits (>= 2).
REQ-002 SHALL have parameter CHUNK, default 4, bits added per cycle; WIDTH % CHUNK == 0, else elaboration error.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operands present.
REQ-006 SHALL have port in_ready  output  1  block idle, can accept operands.
REQ-007 SHALL have port X  input  WIDTH  operand A.
REQ-008 SHALL have port Y  input  WIDTH  operand B.
REQ-009 SHALL have port Cin  input  1  carry-in.
REQ-010 SHALL have port S  output  WIDTH  registered sum.
REQ-011 SHALL have port Cout  output  1  registered carry-out of MSB.
REQ-012 SHALL have port Ovf  output  1  registered two's-complement overflow.
REQ-013 SHALL have port out_valid  output  1  result valid.
REQ-014 SHALL have port out_ready  input  1  consumer accepts result.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DONE; NCH = WIDTH/CHUNK.
REQ-016 IDLE: in_ready=1; in_valid=1 at edge -> capture X, Y, Cin into internal registers, chunk index k=0, go RUN.
REQ-017 RUN: in_ready=0; each cycle add chunk k of X, Y plus carry register, write S[k*CHUNK +: CHUNK], update carry register, k++.
REQ-018 After chunk NCH-1 SHALL go DONE, Cout = final carry, Ovf = carry into MSB XOR carry out of MSB.
REQ-019 Latency: operands accepted at edge t -> out_valid=1 after edge t+NCH (NCH=4 at defaults).
REQ-020 DONE: out_valid=1; S, Cout, Ovf stable until out_valid && out_ready at an edge, then -> IDLE.
REQ-021 in_valid while in RUN or DONE SHALL be ignored; no operand captured, no state change.
REQ-022 S SHALL hold the previous result until chunk writes begin; only DONE marks it valid.
REQ-023 Sum SHALL wrap modulo 2^WIDTH; carry out only via Cout.
REQ-024 Back-to-back: earliest next acceptance is the edge after DONE handshake (throughput one op per NCH+2 cycles).

Reset
REQ-025 rst_n=0 SHALL immediately force state IDLE, k=0, carry register 0, S=0, Cout=0, Ovf=0, out_valid=0; in_ready=1 once rst_n=1.
REQ-026 Reset asserted during RUN or DONE SHALL abort the operation; no partial result ever flagged valid.

Configuration
REQ-027 Macro SERIAL_ADDER_SUB_EN SHALL add input port sub (1 bit), sampled with operands.
REQ-028 With SERIAL_ADDER_SUB_EN and sub=1: compute X + ~Y + 1, Cin ignored; Cout=1 means no borrow; Ovf per signed subtraction.
REQ-029 Without SERIAL_ADDER_SUB_EN: no sub port, add only; behaviour identical to sub=0.

Structure
REQ-030 Shared package adder_pkg SHALL hold the FSM state typedef (IDLE, RUN, DONE) and any shared width-check constants.
REQ-031 One combinational sub-module chunk_adder (parameter CHUNK, inputs a, b, ci; outputs s, co, c_msb_in) SHALL perform the per-cycle ripple add; one instance only.

Verification (WIDTH=8, CHUNK=2 unless stated)
REQ-032 X=0xFF, Y=0x01, Cin=0 -> S=0x00, Cout=1, Ovf=0, out_valid exactly 4 cycles after accept.
REQ-033 X=0x7F, Y=0x01, Cin=0 -> S=0x80, Cout=0, Ovf=1; X=0x80, Y=0x80 -> S=0x00, Cout=1, Ovf=1.
REQ-034 out_ready=0 for 5 cycles in DONE, in_valid=1 with new operands throughout -> S/flags stable, new operands ignored, accepted only after handshake.
REQ-035 rst_n pulsed low at RUN cycle 2 -> all outputs 0 immediately, out_valid never asserted for that op, next op X=0x12, Y=0x34 -> S=0x46.
REQ-036 SERIAL_ADDER_SUB_EN, sub=1, X=0x05, Y=0x07 -> S=0xFE, Cout=0, Ovf=0; X=0x80, Y=0x01 -> S=0x7F, Cout=1, Ovf=1.
REQ-037 Defaults (WIDTH=16, CHUNK=4): 10,000 random operands vs reference model X+Y+Cin, latency 4 on every op.
